hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter REG_ADDR, default `REG_ADDR from define.v, the register-address width.
REQ-002 SHALL have parameter MISS_LIMIT, default 255, the maximum D-cache miss cycles before error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports if_id_src1 and if_id_src2, input, REG_ADDR bits each: the ID-stage source registers.
REQ-006 SHALL have port if_id_uses_src2, input, 1 bit: the ID instruction reads src2.
REQ-007 SHALL have port id_ex_memread, input, 1 bit: the EX instruction is a load.
REQ-008 SHALL have port id_ex_dest_reg, input, REG_ADDR bits: the EX destination register.
REQ-009 SHALL have port branch_taken, input, 1 bit: EX resolved a taken branch or jump.
REQ-010 SHALL have port dcache_req, input, 1 bit: MEM has a valid load or store access.
REQ-011 SHALL have port dcache_ready, input, 1 bit: the D-cache access completes this cycle.
REQ-012 SHALL have port stat_clear, input, 1 bit: synchronous clear of stall_count.
REQ-013 SHALL have outputs pc_write and if_id_write, 1 bit each: PC and IF/ID register enables.
REQ-014 SHALL have output id_ex_bubble, 1 bit: load a NOP into ID/EX.
REQ-015 SHALL have outputs if_id_flush and id_ex_flush, 1 bit each: squash the named stages.
REQ-016 SHALL have output freeze, 1 bit: hold every pipeline register, including EX/MEM and MEM/WB.
REQ-017 SHALL have output stall_count, 16 bits: cycles in which pc_write=0.
REQ-018 SHALL have output miss_err, 1 bit: sticky flag set on a D-cache miss timeout.

Function
REQ-019 The FSM SHALL have three states: RUN, DMISS and BR_PEND.
REQ-020 A load-use hazard (lu) SHALL be: id_ex_memread and id_ex_dest_reg!=0 and (id_ex_dest_reg==if_id_src1, or if_id_uses_src2 and id_ex_dest_reg==if_id_src2).
REQ-021 Outputs SHALL be combinational from state and inputs; stall_count, miss_err and the miss counter SHALL be registered.
REQ-022 In RUN with dcache_req=1 and dcache_ready=0: freeze=1, pc_write=0, if_id_write=0, no flush, no bubble; next state SHALL be DMISS.
REQ-023 In DMISS: freeze, pc_write and if_id_write SHALL hold as in REQ-022; when dcache_ready=1, freeze=0 that same cycle.
REQ-024 On leaving DMISS: next state SHALL be BR_PEND if branch_taken was 1 on any DMISS cycle, else RUN.
REQ-025 In RUN with branch_taken=1 and no miss: if_id_flush=1, id_ex_flush=1, pc_write=1, id_ex_bubble=0; lu SHALL be ignored.
REQ-026 BR_PEND SHALL behave as REQ-025 for exactly one cycle, then go to RUN.
REQ-027 In RUN with lu, no branch and no miss: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle.
REQ-028 With no event: pc_write=1, if_id_write=1, and all other control outputs 0.
REQ-029 Priority SHALL be D-cache miss > branch > load-use.
REQ-030 The miss counter SHALL count DMISS cycles; on reaching MISS_LIMIT, miss_err SHALL be set and the FSM SHALL force RUN.
REQ-031 miss_err SHALL clear only on reset.
REQ-032 stall_count SHALL increment on each cycle with pc_write=0 and saturate at 16'hFFFF.
REQ-033 stat_clear SHALL zero stall_count and take priority over increment.

Reset
REQ-034 On rst_n low: state=RUN, miss counter=0, branch-pending latch=0, stall_count=0, miss_err=0.
REQ-035 While rst_n is low, outputs SHALL be pc_write=1, if_id_write=1, and all others 0.
REQ-036 Reset asserted mid-DMISS SHALL abort the miss immediately, with freeze=0 asynchronously.

Verification
REQ-037 Load-use: id_ex_memread=1, dest=5, if_id_src1=5 -> one cycle of pc_write=0, if_id_write=0, bubble=1; stall_count=1.
REQ-038 Register 0: dest=0, src1=0, memread=1 -> no stall; src2 match with if_id_uses_src2=0 -> no stall.
REQ-039 Branch plus load-use in the same cycle -> if_id_flush=id_ex_flush=1, bubble=0, pc_write=1.
REQ-040 Miss: dcache_req=1, dcache_ready low for 3 cycles, then high -> freeze=1 for 3 cycles, 0 on the ready cycle; stall_count=3.
REQ-041 Branch during miss: branch_taken=1 while in DMISS -> after ready, exactly one flush cycle (BR_PEND), then RUN.
REQ-042 Timeout and reset: dcache_ready held 0 for 255 cycles -> miss_err=1 and state RUN; a stall_count at FFFF stays FFFF; rst_n pulse mid-miss -> all outputs at reset values.

Source files
------------

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, branch flushes and D-cache miss freezes.
// Control outputs are decoded from the FSM state and the current inputs; statistics are registered.
`ifndef REG_ADDR
`define REG_ADDR 5
`endif

module hazard_control #(
  parameter int REG_ADDR   = `REG_ADDR,
  parameter int MISS_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_ADDR-1:0] if_id_src1,
  input  logic [REG_ADDR-1:0] if_id_src2,
  input  logic                if_id_uses_src2,
  input  logic                id_ex_memread,
  input  logic [REG_ADDR-1:0] id_ex_dest_reg,
  input  logic                branch_taken,
  input  logic                dcache_req,
  input  logic                dcache_ready,
  input  logic                stat_clear,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                id_ex_bubble,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                freeze,
  output logic [15:0]         stall_count,
  output logic                miss_err
);

  localparam int CW = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {RUN, DMISS, BR_PEND} state_t;

  state_t        state;
  logic [CW-1:0] miss_cnt;
  logic          br_pend;
  logic          lu;
  logic          miss;
  logic          timeout;

  assign lu = id_ex_memread && (id_ex_dest_reg != '0) &&
              ((id_ex_dest_reg == if_id_src1) ||
               (if_id_uses_src2 && (id_ex_dest_reg == if_id_src2)));

  assign miss = dcache_req && !dcache_ready;

  // miss_cnt already includes the RUN cycle that detected the miss
  assign timeout = (state == DMISS) && !dcache_ready &&
                   ((int'(miss_cnt) + 1) >= MISS_LIMIT);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    freeze       = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (miss) begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        DMISS: begin
          if (!dcache_ready) begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else if (!(br_pend || branch_taken) && lu) begin
            // a pending branch flushes next cycle, so only stall when none is queued
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        BR_PEND: begin
          if (miss) begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      miss_cnt    <= '0;
      br_pend     <= 1'b0;
      stall_count <= 16'h0000;
      miss_err    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (miss) begin
            state    <= DMISS;
            miss_cnt <= CW'(1);
            br_pend  <= 1'b0;
          end
        end
        DMISS: begin
          if (dcache_ready) begin
            state    <= (br_pend || branch_taken) ? BR_PEND : RUN;
            miss_cnt <= '0;
            br_pend  <= 1'b0;
          end else if (timeout) begin
            state    <= RUN;
            miss_cnt <= '0;
            br_pend  <= 1'b0;
            miss_err <= 1'b1;
          end else begin
            miss_cnt <= miss_cnt + 1'b1;
            if (branch_taken) br_pend <= 1'b1;
          end
        end
        BR_PEND: begin
          // a new miss defers the outstanding flush until the miss resolves
          if (miss) begin
            state    <= DMISS;
            miss_cnt <= CW'(1);
            br_pend  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase

      if (stat_clear)
        stall_count <= 16'h0000;
      else if (!pc_write && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: vector table plus hand sequences, checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_hazard_control;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RA-1:0] if_id_src1 = '0;
  logic [RA-1:0] if_id_src2 = '0;
  logic          if_id_uses_src2 = 1'b0;
  logic          id_ex_memread = 1'b0;
  logic [RA-1:0] id_ex_dest_reg = '0;
  logic          branch_taken = 1'b0;
  logic          dcache_req = 1'b0;
  logic          dcache_ready = 1'b0;
  logic          stat_clear = 1'b0;
  logic          pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze;
  logic [15:0]   stall_count;
  logic          miss_err;

  hazard_control #(.REG_ADDR(RA), .MISS_LIMIT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_src1(if_id_src1), .if_id_src2(if_id_src2), .if_id_uses_src2(if_id_uses_src2),
    .id_ex_memread(id_ex_memread), .id_ex_dest_reg(id_ex_dest_reg),
    .branch_taken(branch_taken), .dcache_req(dcache_req), .dcache_ready(dcache_ready),
    .stat_clear(stat_clear),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .freeze(freeze),
    .stall_count(stall_count), .miss_err(miss_err)
  );

  always #5 clk = ~clk;

  // exp bits: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze}
  localparam logic [5:0] E_NONE  = 6'b110000;
  localparam logic [5:0] E_LU    = 6'b001000;
  localparam logic [5:0] E_FLUSH = 6'b110110;
  localparam logic [5:0] E_MISS  = 6'b000001;

  typedef struct {
    logic [RA-1:0] src1;
    logic [RA-1:0] src2;
    logic          uses2;
    logic          memread;
    logic [RA-1:0] dest;
    logic          br;
    logic          req;
    logic          rdy;
    logic          clr;
    logic [5:0]    exp;
  } vec_t;

  typedef struct {
    logic [5:0]  ctrl;
    logic [15:0] stall;
    logic        err;
    int          id;
  } sb_t;

  sb_t         sb[$];
  sb_t         cur;
  int          tests = 0;
  int          fails = 0;
  int          txn = 0;
  logic [15:0] m_stall = 16'h0000;
  logic        m_err = 1'b0;
  vec_t        tbl[12];

  function automatic vec_t mk(input logic [RA-1:0] s1, input logic [RA-1:0] s2, input logic u2,
                              input logic mr, input logic [RA-1:0] d, input logic br,
                              input logic rq, input logic rd, input logic cl, input logic [5:0] e);
    vec_t v;
    v.src1 = s1; v.src2 = s2; v.uses2 = u2; v.memread = mr; v.dest = d;
    v.br = br; v.req = rq; v.rdy = rd; v.clr = cl; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_t r;
    @(posedge clk);
    #1;
    if_id_src1 = v.src1; if_id_src2 = v.src2; if_id_uses_src2 = v.uses2;
    id_ex_memread = v.memread; id_ex_dest_reg = v.dest; branch_taken = v.br;
    dcache_req = v.req; dcache_ready = v.rdy; stat_clear = v.clr;
    r.ctrl = v.exp; r.stall = m_stall; r.err = m_err; r.id = txn;
    txn++;
    sb.push_back(r);
    if (v.clr) m_stall = 16'h0000;
    else if (!v.exp[5] && m_stall != 16'hFFFF) m_stall = m_stall + 16'h0001;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check($sformatf("ctrl[%0d]", cur.id),
            {26'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze},
            {26'd0, cur.ctrl});
      check($sformatf("stall_count[%0d]", cur.id), {16'd0, stall_count}, {16'd0, cur.stall});
      check($sformatf("miss_err[%0d]", cur.id), {31'd0, miss_err}, {31'd0, cur.err});
      $display("[TB] txn %0d ctrl=%b stall=%h err=%b", cur.id,
               {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze},
               stall_count, miss_err);
    end
  end

  initial begin
    tbl[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[1]  = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
    tbl[2]  = mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[3]  = mk(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[4]  = mk(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
    tbl[5]  = mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[6]  = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_FLUSH);
    tbl[7]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_FLUSH);
    tbl[8]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_NONE);
    tbl[9]  = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, E_LU);
    tbl[10] = mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    tbl[11] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_NONE);

    // reset values hold even with every hazard input active
    id_ex_memread = 1'b1; id_ex_dest_reg = 5'd5; if_id_src1 = 5'd5;
    branch_taken = 1'b1; dcache_req = 1'b1; dcache_ready = 1'b0;
    #3;
    check("reset_ctrl", {26'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze},
          {26'd0, E_NONE});
    check("reset_stall", {16'd0, stall_count}, 32'd0);
    check("reset_err", {31'd0, miss_err}, 32'd0);
    id_ex_memread = 1'b0; id_ex_dest_reg = '0; if_id_src1 = '0;
    branch_taken = 1'b0; dcache_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) drive(tbl[i]);

    // three miss cycles then ready; freeze drops on the ready cycle
    for (int i = 0; i < 3; i++) drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_MISS));
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_NONE));
    drive(tbl[0]);

    // branch seen during the miss yields exactly one flush cycle afterwards
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_MISS));
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_MISS));
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_NONE));
    drive(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_FLUSH));
    drive(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LU));
    drive(tbl[0]);

    // miss timeout after 255 cycles of ready low
    for (int i = 0; i < 255; i++) drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_MISS));
    m_err = 1'b1;
    drive(tbl[0]);
    drive(tbl[0]);

    // saturate stall_count with a held load-use stall, then clear it
    drive(tbl[1]);
    repeat (65540) @(posedge clk);
    m_stall = 16'hFFFF;
    drive(tbl[1]);
    drive(tbl[0]);
    drive(mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, E_LU));
    drive(tbl[0]);

    // asynchronous reset in the middle of a miss
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_MISS));
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_MISS));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midmiss_reset_ctrl",
          {26'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, freeze},
          {26'd0, E_NONE});
    check("midmiss_reset_stall", {16'd0, stall_count}, 32'd0);
    check("midmiss_reset_err", {31'd0, miss_err}, 32'd0);
    dcache_req = 1'b0;
    m_stall = 16'h0000;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[0]);
    drive(tbl[8]);
    drive(tbl[1]);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
